// File: rtl/occupancy_tracker_if.sv
// Doorway beam inputs and occupancy status outputs between the home controller and the tracker.
interface occupancy_tracker_if #(
  parameter int NUM_DOORS = 4,
  parameter int COUNT_W   = 8
);
  logic [NUM_DOORS-1:0] ir_outer;
  logic [NUM_DOORS-1:0] ir_inner;
  logic                 occ_clear;
  logic [COUNT_W-1:0]   occupants;
  logic [NUM_DOORS-1:0] entry_pulse;
  logic [NUM_DOORS-1:0] exit_pulse;
  logic                 full;
  logic                 empty;
  logic                 underflow_err;
  logic [NUM_DOORS-1:0] door_fault;

  modport master (
    output ir_outer, ir_inner, occ_clear,
    input  occupants, entry_pulse, exit_pulse, full, empty, underflow_err, door_fault
  );

  modport slave (
    input  ir_outer, ir_inner, occ_clear,
    output occupants, entry_pulse, exit_pulse, full, empty, underflow_err, door_fault
  );
endinterface

// File: rtl/occupancy_tracker.sv
// Multi-doorway occupancy counter: per-beam sync/debounce, per-door direction FSM,
// shared saturating occupant counter with full/empty/underflow status.

module occupancy_beam #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  logic       s1, s2;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // accept a change only after DEBOUNCE consecutive disagreeing samples
      if (s2 != filt) begin
        if (cnt == 4'(DEBOUNCE - 1)) begin
          filt <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module occupancy_door #(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_outer,
  input  logic ir_inner,
  output logic entry_ev,
  output logic exit_ev,
  output logic fault
);
  typedef enum logic [1:0] {IDLE, OUT_FIRST, IN_FIRST, WAIT_CLEAR} state_t;

  state_t      state;
  logic [15:0] tmo;
  logic        o, i;

  occupancy_beam #(.DEBOUNCE(DEBOUNCE)) u_outer (.clk(clk), .reset(reset), .raw(ir_outer), .filt(o));
  occupancy_beam #(.DEBOUNCE(DEBOUNCE)) u_inner (.clk(clk), .reset(reset), .raw(ir_inner), .filt(i));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmo      <= '0;
      entry_ev <= 1'b0;
      exit_ev  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      entry_ev <= 1'b0;
      exit_ev  <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          case ({o, i})
            2'b10:   state <= OUT_FIRST;
            2'b01:   state <= IN_FIRST;
            2'b11: begin
              state <= WAIT_CLEAR;
              fault <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
        OUT_FIRST: begin
          tmo <= tmo + 16'd1;
          // timeout wins over a crossing completing on the same cycle
          if (tmo == 16'(TIMEOUT - 1)) begin
            state <= WAIT_CLEAR;
            fault <= 1'b1;
          end else if ({o, i} == 2'b01) begin
            state    <= WAIT_CLEAR;
            entry_ev <= 1'b1;
          end else if ({o, i} == 2'b00) begin
            state <= IDLE;
          end
        end
        IN_FIRST: begin
          tmo <= tmo + 16'd1;
          if (tmo == 16'(TIMEOUT - 1)) begin
            state <= WAIT_CLEAR;
            fault <= 1'b1;
          end else if ({o, i} == 2'b10) begin
            state   <= WAIT_CLEAR;
            exit_ev <= 1'b1;
          end else if ({o, i} == 2'b00) begin
            state <= IDLE;
          end
        end
        default: begin
          if ({o, i} == 2'b00) state <= IDLE;
        end
      endcase
    end
  end
endmodule

module occupancy_tracker #(
  parameter int NUM_DOORS = 4,
  parameter int COUNT_W   = 8,
  parameter int DEBOUNCE  = 3,
  parameter int TIMEOUT   = 255,
  parameter int MAX_OCC   = 200
) (
  input logic                clk,
  input logic                reset,
  occupancy_tracker_if.slave bus
);
  localparam int SW = COUNT_W + 4;

  logic [NUM_DOORS-1:0] outer_raw, inner_raw;
  logic [NUM_DOORS-1:0] entry_ev, exit_ev, fault;
  logic [NUM_DOORS-1:0] entry_q, exit_q;
  logic [COUNT_W-1:0]   occ_q, occ_next;
  logic                 uf_q, uf_hit;
  logic [3:0]           n_in, n_out;
  logic signed [SW-1:0] net, sum;

  assign outer_raw = bus.ir_outer;
  assign inner_raw = bus.ir_inner;

  occupancy_door #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_door [NUM_DOORS-1:0] (
    .clk      (clk),
    .reset    (reset),
    .ir_outer (outer_raw),
    .ir_inner (inner_raw),
    .entry_ev (entry_ev),
    .exit_ev  (exit_ev),
    .fault    (fault)
  );

  // opposing events cancel first, then the result is clamped to the counter range
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int d = 0; d < NUM_DOORS; d++) begin
      n_in  = n_in  + 4'(entry_ev[d]);
      n_out = n_out + 4'(exit_ev[d]);
    end
    net    = $signed({{COUNT_W{1'b0}}, n_in}) - $signed({{COUNT_W{1'b0}}, n_out});
    sum    = $signed({4'b0, occ_q}) + net;
    uf_hit = 1'b0;
    if (sum < 0) begin
      occ_next = '0;
      uf_hit   = 1'b1;
    end else if (sum > $signed({4'b0, {COUNT_W{1'b1}}})) begin
      occ_next = '1;
    end else begin
      occ_next = sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= '0;
      uf_q    <= 1'b0;
      entry_q <= '0;
      exit_q  <= '0;
    end else begin
      entry_q <= entry_ev;
      exit_q  <= exit_ev;
      if (bus.occ_clear) begin
        occ_q <= '0;
        uf_q  <= 1'b0;
      end else begin
        occ_q <= occ_next;
        if (uf_hit) uf_q <= 1'b1;
      end
    end
  end

  assign bus.occupants     = occ_q;
  assign bus.entry_pulse   = entry_q;
  assign bus.exit_pulse    = exit_q;
  assign bus.underflow_err = uf_q;
  assign bus.door_fault    = fault;
  assign bus.full          = (occ_q >= COUNT_W'(MAX_OCC));
  assign bus.empty         = (occ_q == '0);
endmodule

// File: tb/tb_occupancy_tracker.sv
// Bench for occupancy_tracker: table of crossings with a pulse scoreboard, plus glitch,
// timeout, clear and mid-crossing reset sequences.
module tb_occupancy_tracker;
  localparam int ND = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fault_cnt [ND];

  occupancy_tracker_if #(.NUM_DOORS(ND), .COUNT_W(CW)) bus ();

  occupancy_tracker #(
    .NUM_DOORS(ND), .COUNT_W(CW), .DEBOUNCE(2), .TIMEOUT(20), .MAX_OCC(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] ent;
    logic [ND-1:0] ext;
    int            occ;
  } ev_t;

  typedef struct {
    logic [ND-1:0] ent;
    logic [ND-1:0] ext;
    int            occ;
    bit            full;
    bit            empty;
    bit            uf;
  } vec_t;

  ev_t  sb [$];
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // pulse scoreboard: every entry/exit pulse must match the oldest expected event
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < ND; d++) fault_cnt[d] += int'(bus.door_fault[d]);
      if ((bus.entry_pulse | bus.exit_pulse) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'({bus.entry_pulse, bus.exit_pulse}), 0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("sb_entry_pulse", int'(bus.entry_pulse), int'(e.ent));
          chk("sb_exit_pulse", int'(bus.exit_pulse), int'(e.ext));
          chk("sb_occupants", int'(bus.occupants), e.occ);
        end
      end
    end
  end

  task automatic phase(input logic [ND-1:0] o, input logic [ND-1:0] i, input int n);
    bus.ir_outer = o;
    bus.ir_inner = i;
    repeat (n) @(negedge clk);
  endtask

  // entering doors break outer first, exiting doors break inner first
  task automatic xing(input logic [ND-1:0] ent, input logic [ND-1:0] ext);
    phase(ent, ext, 6);
    phase(ext, ent, 6);
    phase('0, '0, 6);
  endtask

  task automatic chk_status(input string tag, input int occ, input bit f, input bit e, input bit u);
    chk({tag, "_occ"}, int'(bus.occupants), occ);
    chk({tag, "_full"}, int'(bus.full), int'(f));
    chk({tag, "_empty"}, int'(bus.empty), int'(e));
    chk({tag, "_uf"}, int'(bus.underflow_err), int'(u));
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b00, 1, 0, 0, 0};
    vecs[1] = '{2'b01, 2'b10, 1, 0, 0, 0};
    vecs[2] = '{2'b10, 2'b00, 2, 0, 0, 0};
    vecs[3] = '{2'b01, 2'b00, 3, 1, 0, 0};
    vecs[4] = '{2'b10, 2'b00, 4, 1, 0, 0};
    vecs[5] = '{2'b00, 2'b01, 3, 1, 0, 0};
    vecs[6] = '{2'b00, 2'b10, 2, 0, 0, 0};
    vecs[7] = '{2'b00, 2'b01, 1, 0, 0, 0};
    vecs[8] = '{2'b00, 2'b10, 0, 0, 1, 0};
    vecs[9] = '{2'b00, 2'b01, 0, 0, 1, 1};
    for (int d = 0; d < ND; d++) fault_cnt[d] = 0;

    bus.ir_outer  = '0;
    bus.ir_inner  = '0;
    bus.occ_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_status("reset", 0, 0, 1, 0);
    chk("reset_entry", int'(bus.entry_pulse), 0);
    chk("reset_exit", int'(bus.exit_pulse), 0);
    chk("reset_fault", int'(bus.door_fault), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single-cycle glitch on door1 outer must be filtered out
    phase(2'b10, 2'b00, 1);
    phase(2'b00, 2'b00, 12);
    chk_status("glitch", 0, 0, 1, 0);
    chk("glitch_fault", fault_cnt[1], 0);

    for (int k = 0; k < 10; k++) begin
      sb.push_back('{vecs[k].ent, vecs[k].ext, vecs[k].occ});
      xing(vecs[k].ent, vecs[k].ext);
      chk_status($sformatf("vec%0d", k), vecs[k].occ, vecs[k].full, vecs[k].empty, vecs[k].uf);
    end

    // underflow flag is sticky across later counting until cleared
    sb.push_back('{2'b01, 2'b00, 1});
    xing(2'b01, 2'b00);
    chk_status("uf_sticky", 1, 0, 0, 1);
    bus.occ_clear = 1'b1;
    @(negedge clk);
    bus.occ_clear = 1'b0;
    @(negedge clk);
    chk_status("clear", 0, 0, 1, 0);

    // door1 outer held alone: fault after 20 cycles in OUT_FIRST, never counted
    phase(2'b10, 2'b00, 22);
    chk("tmo_early", fault_cnt[1], 0);
    phase(2'b10, 2'b00, 8);
    chk("tmo_fault", fault_cnt[1], 1);
    phase(2'b00, 2'b00, 10);
    chk_status("tmo", 0, 0, 1, 0);

    // reset while door0 is mid-crossing with count 2
    sb.push_back('{2'b01, 2'b00, 1});
    xing(2'b01, 2'b00);
    sb.push_back('{2'b01, 2'b00, 2});
    xing(2'b01, 2'b00);
    chk_status("pre_rst", 2, 0, 0, 0);
    phase(2'b01, 2'b00, 8);
    reset = 1'b0;
    #1;
    chk_status("mid_rst", 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    phase(2'b01, 2'b00, 6);
    phase(2'b00, 2'b00, 10);
    chk_status("post_rst", 0, 0, 1, 0);

    chk("sb_drain", sb.size(), 0);
    chk("fault_door0", fault_cnt[0], 0);
    chk("fault_door1", fault_cnt[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
